// File: rtl/regfile_pkg.sv
// Shared types and widths for the register-file writeback path.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_dual_push_fifo.sv
// Circular buffer accepting up to two pushes and one pop per cycle, with
// age-ordered taps (index 0 = oldest) of every slot for mask/forwarding logic.
module wb_dual_push_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push0,
  input  wb_entry_t                    i_push0_entry,
  input  logic                         i_push1,
  input  wb_entry_t                    i_push1_entry,
  input  logic                         i_pop,
  output wb_entry_t                    o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic [DEPTH-1:0]             o_age_valid,
  output wb_entry_t                    o_age_entry [DEPTH]
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [PTR_W-1:0] w_push1_ptr;
  logic             w_pop;

  // push1 lands right behind push0 when both fire, otherwise in push0's slot
  assign w_push1_ptr = r_wr_ptr + PTR_W'(i_push0);
  assign w_pop       = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_push0) r_mem[r_wr_ptr]    <= i_push0_entry;
      if (i_push1) r_mem[w_push1_ptr] <= i_push1_entry;
      r_wr_ptr <= r_wr_ptr + PTR_W'(i_push0) + PTR_W'(i_push1);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
      r_count  <= r_count + CNT_W'(i_push0) + CNT_W'(i_push1) - CNT_W'(w_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_comb begin
    o_age_valid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      o_age_entry[k] = r_mem[r_rd_ptr + PTR_W'(k)];
      o_age_valid[k] = (CNT_W'(k) < r_count);
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Merges load and ALU result writes into an in-order queue that drains one
// register-file write per cycle, publishing pending-write mask and forwarding.
module regfile_writeback_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mem_valid,
  output logic                        mem_ready,
  input  logic [ADDR_W-1:0]           mem_addr,
  input  logic [DATA_W-1:0]           mem_data,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [ADDR_W-1:0]           alu_addr,
  input  logic [DATA_W-1:0]           alu_data,
  output logic                        write,
  output logic [ADDR_W-1:0]           reg_write_address,
  output logic [DATA_W-1:0]           write_data,
  output logic [NUM_REGS-1:0]         pending_mask,
  input  logic [ADDR_W-1:0]           fwd_addr,
  output logic                        fwd_hit,
  output logic [DATA_W-1:0]           fwd_data,
  output logic [$clog2(DEPTH+1)-1:0]  queue_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0]    w_count;
  logic [CNT_W-1:0]    w_free;
  logic                w_mem_push;
  logic                w_alu_push;
  logic                w_pop;
  wb_entry_t           w_head;
  logic [DEPTH-1:0]    w_age_valid;
  wb_entry_t           w_age_entry [DEPTH];
  logic [NUM_REGS-1:0] w_mask;
  logic                w_fwd_hit;
  logic [DATA_W-1:0]   w_fwd_data;

  logic                r_write;
  logic [ADDR_W-1:0]   r_waddr;
  logic [DATA_W-1:0]   r_wdata;

  // Handshake: a request transfers at a posedge where valid && ready; ready
  // depends only on registered count (and mem_valid for the ALU port), so the
  // load path wins the last free slot. Writes to register 0 transfer but vanish.
  assign w_free     = CNT_W'(DEPTH) - w_count;
  assign mem_ready  = (w_free >= CNT_W'(1));
  assign alu_ready  = (w_free >= CNT_W'(2)) || ((w_free >= CNT_W'(1)) && !mem_valid);
  assign w_mem_push = mem_valid && mem_ready && (mem_addr != REG_ZERO);
  assign w_alu_push = alu_valid && alu_ready && (alu_addr != REG_ZERO);
  assign w_pop      = (w_count != '0);

  wb_dual_push_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_push0       (w_mem_push),
    .i_push0_entry ('{addr: mem_addr, data: mem_data}),
    .i_push1       (w_alu_push),
    .i_push1_entry ('{addr: alu_addr, data: alu_data}),
    .i_pop         (w_pop),
    .o_head        (w_head),
    .o_count       (w_count),
    .o_age_valid   (w_age_valid),
    .o_age_entry   (w_age_entry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_pop) begin
      r_write <= 1'b1;
      r_waddr <= w_head.addr;
      r_wdata <= w_head.data;
    end else begin
      r_write <= 1'b0;
    end
  end

  always_comb begin
    w_mask = '0;
    if (r_write) w_mask = w_mask | reg_onehot(r_waddr);
    for (int k = 0; k < DEPTH; k++) begin
      if (w_age_valid[k]) w_mask = w_mask | reg_onehot(w_age_entry[k].addr);
    end
    w_mask[0] = 1'b0;
  end

  // Output stage is the oldest candidate; later (younger) queue matches override it.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    if (fwd_addr != REG_ZERO) begin
      if (r_write && (r_waddr == fwd_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_wdata;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (w_age_valid[k] && (w_age_entry[k].addr == fwd_addr)) begin
          w_fwd_hit  = 1'b1;
          w_fwd_data = w_age_entry[k].data;
        end
      end
    end
  end

  assign write             = r_write;
  assign reg_write_address = r_waddr;
  assign write_data        = r_wdata;
  assign pending_mask      = w_mask;
  assign fwd_hit           = w_fwd_hit;
  assign fwd_data          = w_fwd_data;
  assign queue_count       = w_count;

endmodule
